// File: rtl/ble_sample_fifo.sv
// ble_sample_fifo: synchronous sample FIFO for the BLE PHY TX/RX datapath.
// It sits between the mapper/demapper stages and holds 2^ADDR_W entries.
// Storage is inferred RAM with a registered read port.
// Ports:
//   clk, reset          - single rising-edge clock; reset is asynchronous, active-high
//   flush               - synchronous clear of pointers, level and error flags
//   we, data_in         - write request and write data
//   re                  - read request
//   data_out, valid_out - registered read data; valid_out is high in the cycle after an accepted read
//   full, empty         - occupancy decodes (level == DEPTH, level == 0)
//   almost_full/empty   - threshold decodes (level >= AFULL_TH, level <= AEMPTY_TH)
//   level               - occupancy, 0..DEPTH
//   overflow, underflow - sticky flags for rejected writes / rejected reads
module ble_sample_fifo #(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned AFULL_TH  = (2 ** ADDR_W) - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags decode the level register directly, with no added latency.
  assign full         = (level == LVL_W'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_W'(AFULL_TH));
  assign almost_empty = (level <= LVL_W'(AEMPTY_TH));

  // Accept decisions are based on the flags at the start of the cycle. Flush blocks both.
  always_comb begin
    wr_acc = we & ~full & ~flush;
    rd_acc = re & ~empty & ~flush;
  end

  // Sample storage. It has no reset, so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read port register and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // data_out keeps the last sample it read.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      // wr_ptr == rd_ptr only when full or empty, and then one of the two requests
      // is rejected. So a read never returns the sample written in the same cycle.
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        data_out <= mem[rd_ptr];
      end
      valid_out <= rd_acc;
      if (we & full) begin
        overflow <= 1'b1;
      end
      if (re & empty) begin
        underflow <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_sample_fifo.sv
// Testbench for ble_sample_fifo with DATA_W=8, ADDR_W=3, AFULL_TH=4 and AEMPTY_TH=2.
// A transaction-level queue model predicts every output.
module tb_ble_sample_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       we;
  logic [7:0] data_in;
  logic       re;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;

  ble_sample_fifo #(
    .DATA_W(8), .ADDR_W(3), .AFULL_TH(4), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .data_in(data_in), .re(re),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state.
  byte unsigned q[$];
  bit           m_ovf;
  bit           m_unf;
  bit           m_valid;
  byte unsigned m_dout;
  int           max_level;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int sz;
    sz = q.size();
    chk({ctx, ":level"},        32'(level),        32'(sz));
    chk({ctx, ":empty"},        32'(empty),        32'(sz == 0));
    chk({ctx, ":full"},         32'(full),         32'(sz == 8));
    chk({ctx, ":almost_full"},  32'(almost_full),  32'(sz >= 4));
    chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
    chk({ctx, ":valid_out"},    32'(valid_out),    32'(m_valid));
    chk({ctx, ":data_out"},     32'(data_out),     32'(m_dout));
    chk({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
    chk({ctx, ":underflow"},    32'(underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = 8'h00;
  endtask

  // One clock with the given requests. Inputs change at posedge+1.
  // Outputs are checked at the next posedge+1.
  task automatic cycle(input bit w, input bit r, input bit f, input byte unsigned d,
                       input string ctx);
    bit was_full;
    bit was_empty;
    we      = w;
    re      = r;
    flush   = f;
    data_in = d;
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (f) begin
      q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      m_valid = r && !was_empty;
      if (m_valid) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    if (q.size() > max_level) max_level = q.size();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; data_in = 8'h00;
    max_level = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    cycle(0, 0, 0, 8'h00, "idle");

    // Fill with 0x10..0x17.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h10 + i), "fill");
    cycle(1, 0, 0, 8'hEE, "ovf_write");
    cycle(1, 1, 0, 8'hAA, "rw_at_full");
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00, "drain");
    cycle(0, 1, 0, 8'h00, "unf_read");
    cycle(0, 0, 0, 8'h00, "unf_hold");
    cycle(1, 1, 0, 8'h55, "rw_at_empty");
    cycle(0, 0, 1, 8'h00, "flush_clr");

    // Reach level 3, then read and write in the same cycle.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'h30 + i), "lvl3");
    cycle(1, 1, 0, 8'h33, "rw_at_3");
    cycle(0, 0, 0, 8'h00, "rw_hold");

    // Interleaved traffic that carries the pointers across 7->0 at least twice.
    for (int i = 0; i < 20; i++) cycle(1, i >= 2, 0, 8'(8'h40 + i), "wrap");
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, "wrap_drain");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, 8'($urandom), "rand");
    chk("max_level", 32'(max_level <= 8), 32'd1);

    // Flush at level 6 with overflow set, and we held high during the flush.
    cycle(0, 0, 1, 8'h00, "pre_flush");
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h60 + i), "refill");
    cycle(1, 0, 0, 8'hEF, "ovf2");
    cycle(0, 1, 0, 8'h00, "to6_a");
    cycle(0, 1, 0, 8'h00, "to6_b");
    cycle(1, 0, 1, 8'h99, "flush_we");
    cycle(0, 0, 0, 8'h00, "post_flush");

    // Asynchronous reset mid-stream at level 5 while a read is in flight.
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'(8'h70 + i), "to6");
    cycle(0, 1, 0, 8'h00, "inflight_rd");
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b0;
    cycle(1, 0, 0, 8'h81, "after_rst_w");
    cycle(0, 1, 0, 8'h00, "after_rst_r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
